// File: rtl/rob_retire_pkg.sv
// Shared constants and types for the reorder buffer / retire slice.
// Physical-register alias width is inherited from the rename stage.
package rob_retire_pkg;
  localparam int PR_ADDR_W = 5;
  localparam int ROB_DEPTH = 32;
  localparam int ROB_IDX_W = 5;
  localparam int RETIRE_W  = 3;
  localparam int ALIAS_W   = 2 * PR_ADDR_W;

  typedef logic [ALIAS_W-1:0] alias_pair_t;
endpackage

// File: rtl/rob_head_scan.sv
// Combinational retire scan: counts contiguous valid+done entries from head,
// capped at RET_W, and reports the candidate retiree indices (wrapping).
module rob_head_scan
  import rob_retire_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = ROB_IDX_W,
  parameter int RET_W = RETIRE_W
) (
  input  logic [DEPTH-1:0]       valid_i,
  input  logic [DEPTH-1:0]       done_i,
  input  logic [IDX_W-1:0]       head_i,
  output logic [1:0]             k_o,
  output logic [RET_W*IDX_W-1:0] idx_o
);

  logic run_s;

  // Stop counting at the first entry that is not ready to retire.
  always_comb begin
    k_o   = 2'd0;
    idx_o = '0;
    run_s = 1'b1;
    for (int r = 0; r < RET_W; r++) begin
      idx_o[r*IDX_W +: IDX_W] = head_i + IDX_W'(r);
      if (run_s && valid_i[idx_o[r*IDX_W +: IDX_W]] && done_i[idx_o[r*IDX_W +: IDX_W]]) begin
        k_o = k_o + 2'd1;
      end else begin
        run_s = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_retire.sv
// Reorder buffer with in-order retire: hands out ROB indices to the renamer,
// tracks completion, and returns retired old aliases to the free pool.
module rob_retire
  import rob_retire_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = ROB_IDX_W
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [WIDTH*IDX_W-1:0]        rob_entries_out,
  output logic                          alloc_ready,
  input  logic                          alloc_valid,
  input  logic [ALIAS_W*WIDTH-1:0]      alloc_old_aliases,
  input  logic [WIDTH-1:0]              cmplt_valid,
  input  logic [WIDTH*IDX_W-1:0]        cmplt_rob_idx,
  output logic [ALIAS_W*RETIRE_W-1:0]   cmplt_free_regs,
  output logic [1:0]                    retire_count,
  output logic [IDX_W:0]                rob_count,
  output logic                          alloc_drop
);

  localparam logic [IDX_W:0] ALLOC_LIMIT = (IDX_W+1)'(DEPTH - WIDTH);

  logic [IDX_W-1:0]            head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]              count_q, count_d;
  logic [DEPTH-1:0]            valid_q, valid_d, done_q, done_d;
  alias_pair_t                 alias_q [DEPTH];
  logic [ALIAS_W*RETIRE_W-1:0] free_q, free_d;
  logic [1:0]                  ret_cnt_q;
  logic                        drop_q;
  logic [1:0]                  k_s;
  logic [RETIRE_W*IDX_W-1:0]   ret_idx_s;
  logic                        alloc_fire_s;

  // Readiness uses the pre-retire count so freed slots are never reused in the same cycle.
  assign alloc_ready     = (count_q <= ALLOC_LIMIT);
  assign alloc_fire_s    = alloc_valid && alloc_ready;
  assign cmplt_free_regs = free_q;
  assign retire_count    = ret_cnt_q;
  assign rob_count       = count_q;
  assign alloc_drop      = drop_q;

  always_comb begin
    rob_entries_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rob_entries_out[i*IDX_W +: IDX_W] = tail_q + IDX_W'(WIDTH - 1 - i);
    end
  end

  rob_head_scan #(.DEPTH(DEPTH), .IDX_W(IDX_W), .RET_W(RETIRE_W)) u_scan (
    .valid_i (valid_q),
    .done_i  (done_q),
    .head_i  (head_q),
    .k_o     (k_s),
    .idx_o   (ret_idx_s)
  );

  // Next state: completion first, then allocation, then retire clears (retire wins).
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    free_d  = '0;
    for (int l = 0; l < WIDTH; l++) begin
      if (cmplt_valid[l] && valid_q[cmplt_rob_idx[l*IDX_W +: IDX_W]]) begin
        done_d[cmplt_rob_idx[l*IDX_W +: IDX_W]] = 1'b1;
      end else begin
        done_d = done_d;
      end
    end
    if (alloc_fire_s) begin
      for (int i = 0; i < WIDTH; i++) begin
        valid_d[tail_q + IDX_W'(WIDTH - 1 - i)] = 1'b1;
        done_d[tail_q + IDX_W'(WIDTH - 1 - i)]  = 1'b0;
      end
      tail_d = tail_q + IDX_W'(WIDTH);
    end else begin
      tail_d = tail_q;
    end
    for (int r = 0; r < RETIRE_W; r++) begin
      if (2'(r) < k_s) begin
        valid_d[ret_idx_s[r*IDX_W +: IDX_W]]  = 1'b0;
        done_d[ret_idx_s[r*IDX_W +: IDX_W]]   = 1'b0;
        free_d[r*ALIAS_W +: ALIAS_W] = alias_q[ret_idx_s[r*IDX_W +: IDX_W]];
      end else begin
        free_d[r*ALIAS_W +: ALIAS_W] = '0;
      end
    end
    head_d  = head_q + IDX_W'(k_s);
    count_d = count_q - (IDX_W+1)'(k_s);
    if (alloc_fire_s) begin
      count_d = count_d + (IDX_W+1)'(WIDTH);
    end else begin
      count_d = count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      done_q    <= '0;
      free_q    <= '0;
      ret_cnt_q <= 2'd0;
      drop_q    <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      free_q    <= free_d;
      ret_cnt_q <= k_s;
      drop_q    <= alloc_valid && !alloc_ready;
    end
  end

  // Alias payload needs no reset: it is only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (!rst && alloc_fire_s) begin
      for (int i = 0; i < WIDTH; i++) begin
        alias_q[tail_q + IDX_W'(WIDTH - 1 - i)] <= alloc_old_aliases[i*ALIAS_W +: ALIAS_W];
      end
    end
  end

endmodule

// File: tb/tb_rob_retire.sv
// Self-checking bench for rob_retire: directed scenarios with a per-entry
// scoreboard of expected freed alias pairs, checked by a retire monitor.
module tb_rob_retire;
  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] rob_entries_out;
  logic        alloc_ready;
  logic        alloc_valid;
  logic [39:0] alloc_old_aliases;
  logic [3:0]  cmplt_valid;
  logic [19:0] cmplt_rob_idx;
  logic [29:0] cmplt_free_regs;
  logic [1:0]  retire_count;
  logic [5:0]  rob_count;
  logic        alloc_drop;

  int          errors = 0;
  int          checks = 0;
  int          tb_tail = 0;
  logic [9:0]  exp_alias [32];
  logic [9:0]  sb_q [$];
  logic [9:0]  mon_got, mon_exp;

  always #5 clk = ~clk;

  rob_retire dut (
    .clk(clk), .rst(rst), .rob_entries_out(rob_entries_out), .alloc_ready(alloc_ready),
    .alloc_valid(alloc_valid), .alloc_old_aliases(alloc_old_aliases), .cmplt_valid(cmplt_valid),
    .cmplt_rob_idx(cmplt_rob_idx), .cmplt_free_regs(cmplt_free_regs), .retire_count(retire_count),
    .rob_count(rob_count), .alloc_drop(alloc_drop)
  );

  function automatic logic [9:0] alias_of(input int e);
    logic [4:0] ev;
    ev = 5'(e);
    return {~ev, ev};
  endfunction

  function automatic logic [19:0] ents(input int t);
    return {5'(t), 5'(t + 1), 5'(t + 2), 5'(t + 3)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2, input logic [9:0] a3);
    alloc_old_aliases = {a0, a1, a2, a3};
    exp_alias[tb_tail % 32]       = a0;
    exp_alias[(tb_tail + 1) % 32] = a1;
    exp_alias[(tb_tail + 2) % 32] = a2;
    exp_alias[(tb_tail + 3) % 32] = a3;
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    tb_tail = (tb_tail + 4) % 32;
  endtask

  task automatic complete4(input int i0, input int i1, input int i2, input int i3);
    int ix [4];
    ix = '{i0, i1, i2, i3};
    for (int l = 0; l < 4; l++) begin
      cmplt_valid[l] = (ix[l] >= 0);
      cmplt_rob_idx[l*5 +: 5] = 5'(ix[l]);
    end
    tick();
    cmplt_valid = 4'd0;
  endtask

  task automatic expect_retire(input int e);
    sb_q.push_back(exp_alias[e % 32]);
  endtask

  // Retire monitor: each retired slot pops the oldest expected pair; idle slots must be 0.
  always @(posedge clk) begin
    #2;
    for (int r = 0; r < 3; r++) begin
      mon_got = cmplt_free_regs[r*10 +: 10];
      checks++;
      if (r < int'(retire_count)) begin
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL sb_unexpected_retire: slot %0d got %h, nothing expected", r, mon_got);
        end else begin
          mon_exp = sb_q.pop_front();
          if (mon_got !== mon_exp) begin errors++; $display("FAIL sb_free_pair: slot %0d got %h want %h", r, mon_got, mon_exp); end
        end
      end else if (mon_got !== 10'd0) begin
        errors++; $display("FAIL sb_idle_slot: slot %0d got %h want 0", r, mon_got);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tb_tail = 0;
    checks++; if (rob_entries_out !== ents(0)) begin errors++; $display("FAIL reset_entries: got %h want %h", rob_entries_out, ents(0)); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", alloc_ready); end
    checks++; if (rob_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", rob_count); end
    checks++; if (cmplt_free_regs !== 30'd0) begin errors++; $display("FAIL reset_free: got %h want 0", cmplt_free_regs); end
    checks++; if (retire_count !== 2'd0 || alloc_drop !== 1'b0) begin errors++; $display("FAIL reset_pulses: got rc=%0d drop=%b want 0 0", retire_count, alloc_drop); end
    tick();
    checks++; if (retire_count !== 2'd0) begin errors++; $display("FAIL idle_retire: got %0d want 0", retire_count); end
  endtask

  task automatic test_basic();
    do_alloc({5'd3, 5'd2}, {5'd5, 5'd4}, {5'd7, 5'd6}, {5'd9, 5'd8});
    checks++; if (rob_count !== 6'd4) begin errors++; $display("FAIL basic_count: got %0d want 4", rob_count); end
    checks++; if (rob_entries_out !== ents(4)) begin errors++; $display("FAIL basic_entries: got %h want %h", rob_entries_out, ents(4)); end
    for (int e = 0; e < 4; e++) expect_retire(e);
    complete4(0, 1, 2, 3);
    tick();
    checks++; if (retire_count !== 2'd3) begin errors++; $display("FAIL basic_rc3: got %0d want 3", retire_count); end
    checks++; if (cmplt_free_regs !== {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2}) begin errors++; $display("FAIL basic_free3: got %h", cmplt_free_regs); end
    tick();
    checks++; if (retire_count !== 2'd1) begin errors++; $display("FAIL basic_rc1: got %0d want 1", retire_count); end
    checks++; if (cmplt_free_regs !== {20'd0, 5'd9, 5'd8}) begin errors++; $display("FAIL basic_free1: got %h", cmplt_free_regs); end
    checks++; if (rob_count !== 6'd0) begin errors++; $display("FAIL basic_empty: got %0d want 0", rob_count); end
  endtask

  task automatic test_out_of_order();
    do_alloc({5'd11, 5'd10}, {5'd13, 5'd12}, {5'd15, 5'd14}, {5'd17, 5'd16});
    complete4(5, -1, -1, -1);
    tick();
    checks++; if (retire_count !== 2'd0) begin errors++; $display("FAIL ooo_blocked: got %0d want 0", retire_count); end
    checks++; if (rob_count !== 6'd4) begin errors++; $display("FAIL ooo_count: got %0d want 4", rob_count); end
    expect_retire(4); expect_retire(5);
    complete4(-1, -1, 4, 4);
    tick();
    checks++; if (retire_count !== 2'd2) begin errors++; $display("FAIL ooo_rc2: got %0d want 2", retire_count); end
    expect_retire(6); expect_retire(7);
    complete4(6, 7, -1, -1);
    tick();
    checks++; if (retire_count !== 2'd2 || rob_count !== 6'd0) begin errors++; $display("FAIL ooo_drain: got rc=%0d cnt=%0d want 2 0", retire_count, rob_count); end
  endtask

  task automatic test_full_and_wrap();
    rst = 1'b1; tick(); rst = 1'b0; tb_tail = 0;
    for (int g = 0; g < 8; g++) do_alloc(alias_of(4*g), alias_of(4*g+1), alias_of(4*g+2), alias_of(4*g+3));
    checks++; if (rob_count !== 6'd32 || alloc_ready !== 1'b0) begin errors++; $display("FAIL full_state: got cnt=%0d rdy=%b want 32 0", rob_count, alloc_ready); end
    alloc_old_aliases = 40'h12345_6789A;
    alloc_valid = 1'b1; tick(); alloc_valid = 1'b0;
    checks++; if (alloc_drop !== 1'b1) begin errors++; $display("FAIL full_drop: got %b want 1", alloc_drop); end
    checks++; if (rob_count !== 6'd32 || rob_entries_out !== ents(0)) begin errors++; $display("FAIL full_nochange: got cnt=%0d ent=%h", rob_count, rob_entries_out); end
    tick();
    checks++; if (alloc_drop !== 1'b0) begin errors++; $display("FAIL drop_pulse: got %b want 0", alloc_drop); end
    expect_retire(0); expect_retire(1); expect_retire(2);
    complete4(0, 1, 2, -1);
    tick();
    checks++; if (rob_count !== 6'd29 || alloc_ready !== 1'b0) begin errors++; $display("FAIL full_29: got cnt=%0d rdy=%b want 29 0", rob_count, alloc_ready); end
    expect_retire(3);
    complete4(3, -1, -1, -1);
    tick();
    checks++; if (rob_count !== 6'd28 || alloc_ready !== 1'b1) begin errors++; $display("FAIL full_28: got cnt=%0d rdy=%b want 28 1", rob_count, alloc_ready); end
    checks++; if (rob_entries_out !== ents(0)) begin errors++; $display("FAIL wrap_entries: got %h want %h", rob_entries_out, ents(0)); end
    do_alloc(alias_of(40), alias_of(41), alias_of(42), alias_of(43));
    for (int j = 0; j < 7; j++) begin
      for (int l = 0; l < 4; l++) if (4 + 4*j + l < 30) expect_retire(4 + 4*j + l);
      complete4(4+4*j, 5+4*j, (6+4*j < 30) ? 6+4*j : -1, (7+4*j < 30) ? 7+4*j : -1);
    end
    for (int n = 0; n < 20 && rob_count != 6'd6; n++) tick();
    checks++; if (rob_count !== 6'd6) begin errors++; $display("FAIL wrap_drain: got %0d want 6", rob_count); end
    expect_retire(30); expect_retire(31); expect_retire(0);
    complete4(30, 31, 0, -1);
    tick();
    checks++; if (retire_count !== 2'd3 || rob_count !== 6'd3) begin errors++; $display("FAIL wrap_retire: got rc=%0d cnt=%0d want 3 3", retire_count, rob_count); end
    expect_retire(1);
    complete4(1, -1, -1, -1);
    tick();
    checks++; if (retire_count !== 2'd1 || rob_count !== 6'd2) begin errors++; $display("FAIL wrap_head1: got rc=%0d cnt=%0d want 1 2", retire_count, rob_count); end
  endtask

  task automatic test_simultaneous();
    do_alloc(alias_of(50), alias_of(51), alias_of(52), alias_of(53));
    do_alloc(alias_of(54), alias_of(55), alias_of(56), alias_of(57));
    checks++; if (rob_count !== 6'd10) begin errors++; $display("FAIL simul_pre: got %0d want 10", rob_count); end
    expect_retire(2); expect_retire(3);
    complete4(2, 3, -1, -1);
    do_alloc(alias_of(60), alias_of(61), alias_of(62), alias_of(63));
    checks++; if (rob_count !== 6'd12 || retire_count !== 2'd2) begin errors++; $display("FAIL simul_count: got cnt=%0d rc=%0d want 12 2", rob_count, retire_count); end
  endtask

  task automatic test_reset_mid();
    complete4(4, -1, -1, -1);
    rst = 1'b1;
    tick();
    checks++; if (rob_count !== 6'd0 || cmplt_free_regs !== 30'd0 || retire_count !== 2'd0) begin errors++; $display("FAIL rst_mid: got cnt=%0d free=%h rc=%0d want 0 0 0", rob_count, cmplt_free_regs, retire_count); end
    checks++; if (rob_entries_out !== ents(0) || alloc_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ptrs: got ent=%h rdy=%b", rob_entries_out, alloc_ready); end
    rst = 1'b0; tb_tail = 0;
    tick();
    checks++; if (retire_count !== 2'd0 || rob_count !== 6'd0) begin errors++; $display("FAIL rst_no_free: got rc=%0d cnt=%0d want 0 0", retire_count, rob_count); end
  endtask

  initial begin
    rst = 1'b1; alloc_valid = 1'b0; alloc_old_aliases = 40'd0;
    cmplt_valid = 4'd0; cmplt_rob_idx = 20'd0;
    test_reset();
    test_basic();
    test_out_of_order();
    test_full_and_wrap();
    test_simultaneous();
    test_reset_mid();
    tick();
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
